// File: rtl/blft_wb_writer.sv
// Write-back stage after the bilateral filter: deduplicates the filtered-pixel stream, buffers it
// in a small FIFO and writes each pixel once to the result SRAM through a ready-gated port.
module blft_wb_writer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_pix_valid,
  input  logic [AW-1:0] i_pix_addr,
  input  logic [DW-1:0] i_pix_data,
  input  logic          i_flt_finish,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic          i_mem_ready,
  output logic [AW:0]   o_pix_count,
  output logic          o_overflow,
  output logic          o_done
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e        r_state;
  state_e        w_state_next;
  logic [PW:0]   r_wptr;
  logic [PW:0]   r_rptr;
  logic [AW-1:0] r_addr_mem [DEPTH];
  logic [DW-1:0] r_data_mem [DEPTH];
  logic          r_last_vld;
  logic [AW-1:0] r_last_addr;
  logic [AW:0]   r_pix_count;
  logic          r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_elig;
  logic w_push;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_pop   = !w_empty && i_mem_ready;
  assign w_elig  = i_pix_valid && (r_state != StDone) &&
                   (!r_last_vld || (i_pix_addr != r_last_addr));
  // A full FIFO still takes the pixel when the head retires in the same cycle.
  assign w_push  = w_elig && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_last_vld  <= 1'b0;
      r_last_addr <= '0;
      r_pix_count <= '0;
      r_overflow  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_addr_mem[i] <= '0;
        r_data_mem[i] <= '0;
      end
    end else begin
      if (w_elig) begin
        r_last_vld  <= 1'b1;
        r_last_addr <= i_pix_addr;
      end
      if (w_elig && !w_push) begin
        r_overflow <= 1'b1;
      end
      if (w_push) begin
        r_addr_mem[r_wptr[PW-1:0]] <= i_pix_addr;
        r_data_mem[r_wptr[PW-1:0]] <= i_pix_data;
        r_wptr                     <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        if (r_pix_count != '1) begin
          r_pix_count <= r_pix_count + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_flt_finish) begin
          w_state_next = StDrain;
        end else if (w_elig) begin
          w_state_next = StRun;
        end
      end
      StRun: begin
        if (i_flt_finish) begin
          w_state_next = StDrain;
        end
      end
      StDrain: begin
        if (w_empty && !w_push) begin
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StDone;
      default: w_state_next = StIdle;
    endcase
  end

  assign o_mem_we    = !w_empty;
  assign o_mem_addr  = r_addr_mem[r_rptr[PW-1:0]];
  assign o_mem_wdata = r_data_mem[r_rptr[PW-1:0]];
  assign o_pix_count = r_pix_count;
  assign o_overflow  = r_overflow;
  assign o_done      = (r_state == StDone);

endmodule

// File: tb/tb_blft_wb_writer.sv
// Self-checking bench for blft_wb_writer: directed scenarios plus randomized traffic, compared
// every cycle against a queue-based model of the write-back behaviour.
module tb_blft_wb_writer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 8;

  logic          clk;
  logic          rst;
  logic          i_pix_valid;
  logic [AW-1:0] i_pix_addr;
  logic [DW-1:0] i_pix_data;
  logic          i_flt_finish;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          i_mem_ready;
  logic [AW:0]   o_pix_count;
  logic          o_overflow;
  logic          o_done;

  blft_wb_writer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_pix_valid (i_pix_valid),
    .i_pix_addr  (i_pix_addr),
    .i_pix_data  (i_pix_data),
    .i_flt_finish(i_flt_finish),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ready (i_mem_ready),
    .o_pix_count (o_pix_count),
    .o_overflow  (o_overflow),
    .o_done      (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: pending pixels in order, plus the sticky flags the outputs expose.
  logic [AW+DW-1:0] m_q[$];
  logic             m_last_vld;
  logic [AW-1:0]    m_last_addr;
  int               m_cnt;
  logic             m_ovf;
  logic             m_fin;
  logic             m_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_last_vld  = 1'b0;
    m_last_addr = '0;
    m_cnt       = 0;
    m_ovf       = 1'b0;
    m_fin       = 1'b0;
    m_done      = 1'b0;
  endtask

  task automatic compare_outputs();
    logic [AW+DW-1:0] head;
    chk("mem_we", 32'(o_mem_we), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      head = m_q[0];
      chk("mem_addr", 32'(o_mem_addr), 32'(head[AW+DW-1:DW]));
      chk("mem_wdata", 32'(o_mem_wdata), 32'(head[DW-1:0]));
    end
    chk("pix_count", 32'(o_pix_count), 32'(m_cnt));
    chk("overflow", 32'(o_overflow), 32'(m_ovf));
    chk("done", 32'(o_done), 32'(m_done));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare mid-cycle.
  task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic f, input logic rdy);
    logic pre_empty, pop, elig, push;
    i_pix_valid  = v;
    i_pix_addr   = a;
    i_pix_data   = d;
    i_flt_finish = f;
    i_mem_ready  = rdy;
    @(posedge clk);
    pre_empty = (m_q.size() == 0);
    pop       = !pre_empty && rdy;
    elig      = v && !m_done && (!m_last_vld || a != m_last_addr);
    push      = elig && ((m_q.size() < DEPTH) || pop);
    if (elig) begin
      m_last_vld  = 1'b1;
      m_last_addr = a;
    end
    if (elig && !push) m_ovf = 1'b1;
    if (pop) begin
      void'(m_q.pop_front());
      m_cnt++;
    end
    if (push) m_q.push_back({a, d});
    if (!m_done && m_fin && pre_empty && !push) m_done = 1'b1;
    if (f) m_fin = 1'b1;
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_mem_we", 32'(o_mem_we), 32'd0);
    chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(o_mem_wdata), 32'd0);
    chk("rst_pix_count", 32'(o_pix_count), 32'd0);
    chk("rst_overflow", 32'(o_overflow), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [AW-1:0] addr;
    int            pct;
    int            guard;
    rst          = 1'b1;
    i_pix_valid  = 1'b0;
    i_pix_addr   = '0;
    i_pix_data   = '0;
    i_flt_finish = 1'b0;
    i_mem_ready  = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single pixel, then dedup of a held pixel.
    step(1'b1, 16'h0505, 8'h3C, 1'b0, 1'b1);
    chk("single_we", 32'(o_mem_we), 32'd1);
    chk("single_addr", 32'(o_mem_addr), 32'h0505);
    step(1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
    chk("single_cnt", 32'(o_pix_count), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0506, 8'h11, 1'b0, 1'b1);
    step(1'b1, 16'h0507, 8'h22, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
    chk("dedup_cnt", 32'(o_pix_count), 32'd3);

    // Backpressure: ninth pixel dropped, then eight back-to-back writes.
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 16'(16'h0100 + i), 8'(8'hA0 + i), 1'b0, 1'b0);
    chk("full_ovf", 32'(o_overflow), 32'd1);
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
    chk("full_cnt", 32'(o_pix_count), 32'd8);

    // Full FIFO with a pop in the same cycle still accepts the pixel.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h0200 + i), 8'(i), 1'b0, 1'b0);
    step(1'b1, 16'h02FF, 8'h5A, 1'b0, 1'b1);
    chk("full_pop_ovf", 32'(o_overflow), 32'd0);

    // Finish and drain, then later pixels are ignored.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h0300 + i), 8'(8'h30 + i), 1'b0, 1'b0);
    step(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 8'h0, 1'b1, 1'b1);
    chk("drain_done", 32'(o_done), 32'd1);
    step(1'b1, 16'h0399, 8'h77, 1'b1, 1'b1);
    step(1'b0, 16'h0, 8'h0, 1'b1, 1'b1);
    chk("done_ignore_cnt", 32'(o_pix_count), 32'd3);

    // Reset with five entries buffered.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h0400 + i), 8'(i), 1'b0, 1'b0);
    do_reset();
    step(1'b0, 16'h0, 8'h0, 1'b0, 1'b1);

    // Randomized runs with different SRAM readiness.
    for (int r = 0; r < 4; r++) begin
      pct  = (r == 0) ? 90 : (r == 1) ? 50 : (r == 2) ? 15 : 100;
      addr = 16'($urandom);
      do_reset();
      for (int c = 0; c < 250; c++) begin
        if ($urandom_range(0, 99) < 40) addr = 16'($urandom_range(0, 31));
        step(1'($urandom_range(0, 99) < 65), addr, 8'($urandom), 1'(c >= 180),
             1'($urandom_range(0, 99) < pct));
      end
      guard = 0;
      while (!m_done && guard < 100) begin
        step(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 1'b1, 1'b1);
        guard++;
      end
      chk("rand_done_reached", 32'(o_done), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
